// File: rtl/branch_pc_ctrl.sv
// Program-counter owner: issues PCs to fetch, resolves branch/jump outcomes, and
// on a redirect loads the target and inserts FLUSH_CYCLES bubble cycles.
module branch_pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       funct,
    input  logic             B,
    input  logic             J,
    input  logic             JR,
    input  logic             BrEq,
    input  logic             BrLT,
    input  logic             work,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    input  logic             instr_valid,
    input  logic             fetch_ready,
    output logic [31:0]      pc,
    output logic             pc_valid,
    output logic             PCSel,
    output logic             flush,
    output logic             err,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {ISSUE, WAIT, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               pc_valid_q, pc_valid_d;
    logic               pcsel_q, pcsel_d;
    logic               err_q, err_d;
    logic [3:0]         fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

    logic               cond_taken, cond_err;
    logic               is_jump, taken, redirect, res_err;
    logic [31:0]        target, seq_pc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        cond_taken = 1'b0;
        cond_err   = 1'b0;
        case (funct)
            3'b000:          cond_taken = BrEq;
            3'b001:          cond_taken = ~BrEq;
            3'b100, 3'b110:  cond_taken = BrLT;
            3'b101, 3'b111:  cond_taken = ~BrLT;
            default:         cond_err   = 1'b1;
        endcase
        if (!work) begin
            cond_taken = 1'b0;
            cond_err   = 1'b1;
        end
    end

    // Only the highest-priority instruction type is evaluated: JR > J > B.
    always_comb begin
        is_jump  = JR | J;
        taken    = is_jump | (B & cond_taken);
        target   = JR ? ((rs1_data + imm) & ~32'd1) : (pc_q + imm);
        seq_pc   = pc_q + 32'd4;
        redirect = taken & ~target[1];
        res_err  = (~is_jump & B & cond_err) | (taken & target[1]);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pcsel_d     = 1'b0;
        err_d       = 1'b0;
        fcnt_d      = fcnt_q;
        taken_cnt_d = taken_cnt_q;
        case (state_q)
            ISSUE: begin
                if (pc_valid_q && fetch_ready) state_d = WAIT;
            end
            WAIT: begin
                if (instr_valid) begin
                    err_d = res_err;
                    if (redirect) begin
                        pc_d        = target;
                        pcsel_d     = 1'b1;
                        taken_cnt_d = sat_inc(taken_cnt_q);
                        fcnt_d      = 4'(FLUSH_CYCLES);
                        state_d     = FLUSH;
                    end else begin
                        pc_d    = seq_pc;
                        state_d = ISSUE;
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q <= 4'd1) state_d = ISSUE;
                else                fcnt_d  = fcnt_q - 4'd1;
            end
            default: state_d = ISSUE;
        endcase
        pc_valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ISSUE;
            pc_q        <= RESET_PC;
            pc_valid_q  <= 1'b0;
            pcsel_q     <= 1'b0;
            err_q       <= 1'b0;
            fcnt_q      <= 4'd0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            pcsel_q     <= pcsel_d;
            err_q       <= err_d;
            fcnt_q      <= fcnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign PCSel     = pcsel_q;
    assign flush     = (state_q == FLUSH);
    assign err       = err_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed bench for branch_pc_ctrl: sequential fetch, branches, jumps, errors,
// PC wrap, fetch back-pressure and reset during a flush.
module tb_branch_pc_ctrl;

    localparam int FL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  funct;
    logic        B, J, JR, BrEq, BrLT, work;
    logic [31:0] imm, rs1_data;
    logic        instr_valid, fetch_ready;
    logic [31:0] pc;
    logic        pc_valid, PCSel, flush, err;
    logic [15:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    branch_pc_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(FL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .funct(funct), .B(B), .J(J), .JR(JR),
        .BrEq(BrEq), .BrLT(BrLT), .work(work), .imm(imm), .rs1_data(rs1_data),
        .instr_valid(instr_valid), .fetch_ready(fetch_ready),
        .pc(pc), .pc_valid(pc_valid), .PCSel(PCSel), .flush(flush),
        .err(err), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        funct = 3'b0; B = 0; J = 0; JR = 0; BrEq = 0; BrLT = 0; work = 0;
        imm = 32'h0; rs1_data = 32'h0; instr_valid = 0;
    endtask

    // Hand the current PC to fetch, then resolve one instruction in WAIT.
    task automatic do_cycle(input logic b, input logic j, input logic jr,
                            input logic [2:0] f, input logic eq, input logic lt,
                            input logic wk, input logic [31:0] im, input logic [31:0] rs);
        fetch_ready = 1;
        tick();
        funct = f; B = b; J = j; JR = jr; BrEq = eq; BrLT = lt; work = wk;
        imm = im; rs1_data = rs; instr_valid = 1;
        tick();
        clear_inputs();
    endtask

    task automatic skip_flush();
        repeat (FL) tick();
    endtask

    task automatic test_reset();
        rst = 1; fetch_ready = 0; clear_inputs();
        tick(); tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_pc_valid: got %b want 0", pc_valid); end
        checks++; if ({PCSel, flush, err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {PCSel, flush, err}); end
        checks++; if (taken_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", taken_cnt); end
        rst = 0;
        tick();
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: got %b want 1", pc_valid); end
    endtask

    task automatic test_sequential();
        fetch_ready = 1;
        tick();
        checks++; if (pc_valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL wait_state: got valid=%b pc=%h want 0/0", pc_valid, pc); end
        instr_valid = 1;
        tick();
        instr_valid = 0;
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h want 4", pc); end
        checks++; if ({PCSel, flush, pc_valid} !== 3'b001) begin errors++; $display("FAIL seq_flags4: got %b want 001", {PCSel, flush, pc_valid}); end
        do_cycle(0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0);
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc8: got %h want 8", pc); end
        checks++; if ({PCSel, flush} !== 2'b00) begin errors++; $display("FAIL seq_flags8: got %b want 00", {PCSel, flush}); end
    endtask

    task automatic test_branch_taken();
        do_cycle(0, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'h100);
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jr_to_100: got %h want 100", pc); end
        skip_flush();
        do_cycle(1, 0, 0, 3'b000, 1, 0, 1, 32'hFFFF_FFF8, 32'h0);
        checks++; if (pc !== 32'hF8) begin errors++; $display("FAIL beq_pc: got %h want f8", pc); end
        checks++; if ({PCSel, flush, pc_valid} !== 3'b110) begin errors++; $display("FAIL beq_flags0: got %b want 110", {PCSel, flush, pc_valid}); end
        checks++; if (taken_cnt !== 16'd2) begin errors++; $display("FAIL beq_cnt: got %0d want 2", taken_cnt); end
        tick();
        checks++; if ({PCSel, flush, pc_valid} !== 3'b010) begin errors++; $display("FAIL beq_flags1: got %b want 010", {PCSel, flush, pc_valid}); end
        tick();
        checks++; if ({PCSel, flush, pc_valid} !== 3'b001) begin errors++; $display("FAIL beq_flags2: got %b want 001", {PCSel, flush, pc_valid}); end
    endtask

    task automatic test_branch_cond();
        do_cycle(0, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'h20);
        skip_flush();
        do_cycle(1, 0, 0, 3'b101, 0, 1, 1, 32'h40, 32'h0);
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL bge_nt_pc: got %h want 24", pc); end
        checks++; if ({PCSel, flush, err, pc_valid} !== 4'b0001) begin errors++; $display("FAIL bge_nt_flags: got %b want 0001", {PCSel, flush, err, pc_valid}); end
        do_cycle(1, 0, 0, 3'b011, 1, 1, 1, 32'h40, 32'h0);
        checks++; if (pc !== 32'h28 || err !== 1'b1) begin errors++; $display("FAIL bad_funct: got pc=%h err=%b want 28/1", pc, err); end
        do_cycle(1, 0, 0, 3'b000, 1, 0, 0, 32'h40, 32'h0);
        checks++; if (pc !== 32'h2C || err !== 1'b1 || PCSel !== 1'b0) begin errors++; $display("FAIL no_work: got pc=%h err=%b sel=%b want 2c/1/0", pc, err, PCSel); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b want 0", err); end
        do_cycle(1, 0, 0, 3'b001, 0, 0, 1, 32'h8, 32'h0);
        checks++; if (pc !== 32'h34 || PCSel !== 1'b1) begin errors++; $display("FAIL bne_taken: got pc=%h sel=%b want 34/1", pc, PCSel); end
        skip_flush();
        do_cycle(1, 0, 0, 3'b100, 0, 1, 1, 32'h10, 32'h0);
        checks++; if (pc !== 32'h44 || taken_cnt !== 16'd5) begin errors++; $display("FAIL blt_taken: got pc=%h cnt=%0d want 44/5", pc, taken_cnt); end
        skip_flush();
    endtask

    task automatic test_jumps();
        do_cycle(0, 0, 1, 3'b000, 0, 0, 0, 32'h4, 32'h1001);
        checks++; if (pc !== 32'h1004 || PCSel !== 1'b1) begin errors++; $display("FAIL jalr: got pc=%h sel=%b want 1004/1", pc, PCSel); end
        skip_flush();
        do_cycle(0, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'h1002);
        checks++; if (pc !== 32'h1008 || err !== 1'b1 || PCSel !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL jalr_misalign: got pc=%h err=%b sel=%b fl=%b want 1008/1/0/0", pc, err, PCSel, flush); end
        checks++; if (taken_cnt !== 16'd6) begin errors++; $display("FAIL misalign_cnt: got %0d want 6", taken_cnt); end
        do_cycle(0, 1, 0, 3'b000, 0, 0, 0, 32'h10, 32'h0);
        checks++; if (pc !== 32'h1018) begin errors++; $display("FAIL jal: got %h want 1018", pc); end
        skip_flush();
        do_cycle(1, 1, 1, 3'b000, 1, 0, 1, 32'h0, 32'h200);
        checks++; if (pc !== 32'h200 || taken_cnt !== 16'd8) begin errors++; $display("FAIL jr_priority: got pc=%h cnt=%0d want 200/8", pc, taken_cnt); end
        skip_flush();
    endtask

    task automatic test_wrap_and_hold();
        do_cycle(0, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'hFFFF_FFFC);
        skip_flush();
        fetch_ready = 0; J = 1; imm = 32'h40; instr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'hFFFF_FFFC || pc_valid !== 1'b1) begin errors++; $display("FAIL hold_%0d: got pc=%h valid=%b want fffffffc/1", i, pc, pc_valid); end
        end
        clear_inputs();
        do_cycle(0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0);
        checks++; if (pc !== 32'h0 || flush !== 1'b0) begin errors++; $display("FAIL wrap: got pc=%h fl=%b want 0/0", pc, flush); end
    endtask

    task automatic test_reset_in_flush();
        do_cycle(0, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'h40);
        checks++; if (flush !== 1'b1 || taken_cnt !== 16'd10) begin errors++; $display("FAIL pre_rst_flush: got fl=%b cnt=%0d want 1/10", flush, taken_cnt); end
        rst = 1;
        tick();
        checks++; if (pc !== 32'h0 || flush !== 1'b0 || taken_cnt !== 16'd0 || PCSel !== 1'b0) begin errors++; $display("FAIL rst_flush: got pc=%h fl=%b cnt=%0d sel=%b want 0/0/0/0", pc, flush, taken_cnt, PCSel); end
        rst = 0;
        tick();
        checks++; if (pc_valid !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL rst_issue: got valid=%b fl=%b want 1/0", pc_valid, flush); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_taken();
        test_branch_cond();
        test_jumps();
        test_wrap_and_hold();
        test_reset_in_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
